hs_link_buffer: RTL and testbench

HS_LINK_BUFFER -- requirements
Module: hs_link_buffer

---
 rtl/hs_link_buffer.sv | 151 +++++++++++++++
 tb/tb_hs_link_buffer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_link_buffer.sv
// Four-phase handshake link buffer: a producer-side FSM writes into a
// DEPTH-entry FIFO and a consumer-side FSM drains it through an output register.
module hs_link_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_req,
    output logic                       in_ack,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_req,
    input  logic                       out_ack,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        IN_IDLE,
        IN_HOLD
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_RTZ
    } out_state_t;

    in_state_t        in_state;
    out_state_t       out_state;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DATA_W-1:0] mem [DEPTH];
    logic             run;
    logic             push;
    logic             pop;

    // Single release flop: state first moves on the second posedge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Full is judged on the registered count, so a same-edge pop never frees a slot.
    assign push = run && (in_state == IN_IDLE) && in_req && !full;
    assign pop  = run && (out_state == OUT_IDLE) && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state <= IN_IDLE;
            in_ack   <= 1'b0;
            tail     <= '0;
        end else if (run) begin
            case (in_state)
                IN_IDLE: begin
                    if (push) begin
                        in_ack   <= 1'b1;
                        in_state <= IN_HOLD;
                    end
                end
                IN_HOLD: begin
                    if (!in_req) begin
                        in_ack   <= 1'b0;
                        in_state <= IN_IDLE;
                    end
                end
                default: begin
                    in_ack   <= 1'b0;
                    in_state <= IN_IDLE;
                end
            endcase
            if (flush) begin
                tail <= '0;
            end else if (push) begin
                tail <= tail + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= OUT_IDLE;
            out_req   <= 1'b0;
            out_data  <= '0;
            head      <= '0;
        end else if (run) begin
            case (out_state)
                OUT_IDLE: begin
                    if (pop) begin
                        out_data  <= mem[head];
                        out_req   <= 1'b1;
                        out_state <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (out_ack) begin
                        out_req   <= 1'b0;
                        out_state <= OUT_RTZ;
                    end
                end
                OUT_RTZ: begin
                    if (!out_ack) begin
                        out_state <= OUT_IDLE;
                    end
                end
                default: begin
                    out_req   <= 1'b0;
                    out_state <= OUT_IDLE;
                end
            endcase
            if (flush) begin
                head <= '0;
            end else if (pop) begin
                head <= head + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (run) begin
            if (flush) begin
                count <= '0;
            end else if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hs_link_buffer.sv
// Bench for hs_link_buffer: cycle table and directed handshake sequences on a
// 16x4 instance, random-stall stress on an 8x8 instance against a queue model.
module tb_hs_link_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic        a_in_req = 1'b0, a_in_ack, a_out_req, a_out_ack = 1'b0, a_flush = 1'b0;
    logic        a_full, a_empty;
    logic [15:0] a_in_data = '0, a_out_data;
    logic [2:0]  a_count;

    logic        b_in_req = 1'b0, b_in_ack, b_out_req, b_out_ack = 1'b0, b_flush = 1'b0;
    logic        b_full, b_empty;
    logic [7:0]  b_in_data = '0, b_out_data;
    logic [3:0]  b_count;

    hs_link_buffer #(.DATA_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_req(a_in_req), .in_ack(a_in_ack), .in_data(a_in_data),
        .out_req(a_out_req), .out_ack(a_out_ack), .out_data(a_out_data), .flush(a_flush),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    hs_link_buffer #(.DATA_W(8), .DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_req(b_in_req), .in_ack(b_in_ack), .in_data(b_in_data),
        .out_req(b_out_req), .out_ack(b_out_ack), .out_data(b_out_data), .flush(b_flush),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return a_in_ack;
            1: return a_out_req;
            2: return b_in_ack;
            default: return b_out_req;
        endcase
    endfunction

    task automatic wait_level(input int w, input logic lvl, input string nm);
        int n = 0;
        while (sig(w) !== lvl && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, 32'(sig(w)), 32'(lvl));
    endtask

    task automatic step(input logic req, input logic [15:0] d, input logic oack, input logic fl);
        a_in_req  = req;
        a_in_data = d;
        a_out_ack = oack;
        a_flush   = fl;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ack"},   32'(a_in_ack),   0);
        check({tag, "_out_req"},  32'(a_out_req),  0);
        check({tag, "_out_data"}, 32'(a_out_data), 0);
        check({tag, "_count"},    32'(a_count),    0);
        check({tag, "_empty"},    32'(a_empty),    1);
        check({tag, "_full"},     32'(a_full),     0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic a_send(input logic [15:0] d);
        a_in_data = d;
        a_in_req  = 1'b1;
        wait_level(0, 1'b1, "a_send_ack");
        a_in_req = 1'b0;
        wait_level(0, 1'b0, "a_send_rtz");
    endtask

    task automatic a_recv(input logic [15:0] exp);
        wait_level(1, 1'b1, "a_recv_req");
        check("a_recv_data", 32'(a_out_data), 32'(exp));
        a_out_ack = 1'b1;
        wait_level(1, 1'b0, "a_recv_rtz");
        a_out_ack = 1'b0;
    endtask

    typedef struct {
        logic        req;
        logic [15:0] d;
        logic        oack;
        logic        fl;
        logic        ack_e;
        logic        oreq_e;
        logic [15:0] od_e;
        logic [2:0]  cnt_e;
        logic        full_e;
        logic        empty_e;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic req, input logic [15:0] d, input logic oack, input logic fl,
                       input logic ack_e, input logic oreq_e, input logic [15:0] od_e,
                       input logic [2:0] cnt_e, input logic full_e, input logic empty_e);
        vec_t v;
        v = '{req, d, oack, fl, ack_e, oreq_e, od_e, cnt_e, full_e, empty_e};
        tbl.push_back(v);
    endtask

    logic [15:0] a_q[$];
    logic [7:0]  b_q[$];
    bit          mon_on = 1'b0;
    int          pushes = 0;
    int          loads  = 0;
    logic        p_ack = 1'b0, p_oreq = 1'b0, p_oack = 1'b0;
    logic [7:0]  p_data = '0;

    // Occupancy is predicted purely from observed handshake events.
    always @(negedge clk) begin
        if (mon_on) begin
            if (b_in_ack && !p_ack) pushes++;
            if (b_out_req && !p_oreq) loads++;
            check("b_count", 32'(b_count), 32'(pushes - loads));
            check("b_full", 32'(b_full), 32'((pushes - loads) == 8));
            if (p_oreq && b_out_req) check("b_data_hold", 32'(b_out_data), 32'(p_data));
            if (p_oreq && !b_out_req) check("b_req_drop_needs_ack", 32'(p_oack), 1);
            p_ack  = b_in_ack;
            p_oreq = b_out_req;
            p_oack = b_out_ack;
            p_data = b_out_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single word + fill to full with a stalled consumer, then refused push at full.
        add(1, 16'hA5A5, 0, 0,  0, 0, 16'h0000, 0, 0, 1);
        add(1, 16'hA5A5, 0, 0,  1, 0, 16'h0000, 1, 0, 0);
        add(0, 16'hA5A5, 0, 0,  0, 1, 16'hA5A5, 0, 0, 1);
        add(0, 16'h0000, 1, 0,  0, 0, 16'hA5A5, 0, 0, 1);
        add(0, 16'h0000, 0, 0,  0, 0, 16'hA5A5, 0, 0, 1);
        add(1, 16'h0001, 0, 0,  1, 0, 16'hA5A5, 1, 0, 0);
        add(0, 16'h0001, 0, 0,  0, 1, 16'h0001, 0, 0, 1);
        add(1, 16'h0002, 0, 0,  1, 1, 16'h0001, 1, 0, 0);
        add(0, 16'h0002, 0, 0,  0, 1, 16'h0001, 1, 0, 0);
        add(1, 16'h0003, 0, 0,  1, 1, 16'h0001, 2, 0, 0);
        add(0, 16'h0003, 0, 0,  0, 1, 16'h0001, 2, 0, 0);
        add(1, 16'h0004, 0, 0,  1, 1, 16'h0001, 3, 0, 0);
        add(0, 16'h0004, 0, 0,  0, 1, 16'h0001, 3, 0, 0);
        add(1, 16'h0005, 0, 0,  1, 1, 16'h0001, 4, 1, 0);
        add(0, 16'h0005, 0, 0,  0, 1, 16'h0001, 4, 1, 0);
        add(1, 16'h0006, 0, 0,  0, 1, 16'h0001, 4, 1, 0);
        add(1, 16'h0006, 0, 0,  0, 1, 16'h0001, 4, 1, 0);
        add(1, 16'h0006, 1, 0,  0, 0, 16'h0001, 4, 1, 0);
        add(1, 16'h0006, 0, 0,  0, 0, 16'h0001, 4, 1, 0);
        add(1, 16'h0006, 0, 0,  0, 1, 16'h0002, 3, 0, 0);
        add(1, 16'h0006, 0, 0,  1, 1, 16'h0002, 4, 1, 0);

        #2;
        pulse_reset("rst0");
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].d, tbl[i].oack, tbl[i].fl);
            check($sformatf("tbl%0d_in_ack", i),   32'(a_in_ack),   32'(tbl[i].ack_e));
            check($sformatf("tbl%0d_out_req", i),  32'(a_out_req),  32'(tbl[i].oreq_e));
            check($sformatf("tbl%0d_out_data", i), 32'(a_out_data), 32'(tbl[i].od_e));
            check($sformatf("tbl%0d_count", i),    32'(a_count),    32'(tbl[i].cnt_e));
            check($sformatf("tbl%0d_full", i),     32'(a_full),     32'(tbl[i].full_e));
            check($sformatf("tbl%0d_empty", i),    32'(a_empty),    32'(tbl[i].empty_e));
        end

        // Reset while both handshakes are open, stale in_req held across release.
        a_in_data = 16'h7777;
        pulse_reset("rst_mid");
        step(1, 16'h7777, 0, 0);
        check("stale_req_ignored", 32'(a_in_ack), 0);
        step(1, 16'h7777, 0, 0);
        check("fresh_ack", 32'(a_in_ack), 1);
        step(0, 16'h7777, 0, 0);
        check("fresh_out_req", 32'(a_out_req), 1);
        a_recv(16'h7777);

        // Simultaneous push and pop at count 2, then 20 words through wrapping pointers.
        a_in_req = 1'b0;
        pulse_reset("rst1");
        a_send(16'h0101);
        a_send(16'h0202);
        a_send(16'h0303);
        check("pp_pre_count", 32'(a_count), 2);
        step(0, 16'h0000, 1, 0);
        step(0, 16'h0000, 0, 0);
        step(1, 16'h0404, 0, 0);
        check("pp_count", 32'(a_count), 2);
        check("pp_in_ack", 32'(a_in_ack), 1);
        check("pp_out_data", 32'(a_out_data), 16'h0202);
        step(0, 16'h0404, 0, 0);
        a_q = '{16'h0202, 16'h0303, 16'h0404};
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [15:0] w;
                    w = 16'($urandom);
                    a_q.push_back(w);
                    a_send(w);
                end
            end
            begin
                for (int i = 0; i < 23; i++) begin
                    logic [15:0] e;
                    int n;
                    n = 0;
                    while (a_q.size() == 0 && n < 500) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    e = (a_q.size() != 0) ? a_q.pop_front() : 16'hxxxx;
                    a_recv(e);
                end
            end
        join
        check("wrap_drained", 32'(a_empty), 1);

        // Flush with three stored words while 0x1111 sits in the output register.
        pulse_reset("rst2");
        a_send(16'h1111);
        a_send(16'h2222);
        a_send(16'h3333);
        a_send(16'h4444);
        check("fl_pre_count", 32'(a_count), 3);
        step(0, 16'h0000, 0, 1);
        check("fl_count", 32'(a_count), 0);
        check("fl_empty", 32'(a_empty), 1);
        check("fl_out_req", 32'(a_out_req), 1);
        check("fl_out_data", 32'(a_out_data), 16'h1111);
        step(1, 16'h5555, 0, 1);
        check("fl_push_ack", 32'(a_in_ack), 1);
        check("fl_push_count", 32'(a_count), 0);
        step(0, 16'h5555, 0, 0);
        check("fl_push_rtz", 32'(a_in_ack), 0);
        a_recv(16'h1111);
        a_send(16'h6666);
        a_recv(16'h6666);
        check("fl_final_empty", 32'(a_empty), 1);

        // Random stall stress on the 8x8 instance.
        pulse_reset("rst3");
        @(posedge clk); #1;
        mon_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] w;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                    w = 8'($urandom);
                    b_q.push_back(w);
                    b_in_data = w;
                    b_in_req  = 1'b1;
                    wait_level(2, 1'b1, "b_send_ack");
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    b_in_req = 1'b0;
                    wait_level(2, 1'b0, "b_send_rtz");
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] e;
                    wait_level(3, 1'b1, "b_recv_req");
                    e = (b_q.size() != 0) ? b_q.pop_front() : 8'hxx;
                    check("b_recv_data", 32'(b_out_data), 32'(e));
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk); #1;
                    end
                    b_out_ack = 1'b1;
                    wait_level(3, 1'b0, "b_recv_rtz");
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    b_out_ack = 1'b0;
                end
            end
        join
        @(posedge clk); #1;
        mon_on = 1'b0;
        check("b_scoreboard_empty", 32'(b_q.size()), 0);
        check("b_final_empty", 32'(b_empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
